xnor_match_pipe: RTL
====================

// Module: xnor_match_pipe
// PURPOSE
//  Parametrised, pipelined word comparator built from NOR-only gate-level XNOR cells.
//  Streams input words against a programmable reference value under a per-bit compare mask.
//  Returns a match flag, a per-bit mismatch vector and a saturating match counter.
//  Sits between a data-stream source and a pattern/trigger consumer; valid/ready on both sides.
// PARAMETERS
//  WIDTH   8  data/reference/mask width in bits (>=2)
//  CNT_W   8  match counter width; saturates at 2**CNT_W-1
// PORTS
//  clk        in   1      single clock, rising edge
//  rst_n      in   1      asynchronous, active-low reset
//  in_valid   in   1      input word valid
//  in_ready   out  1      block accepts in_data this cycle
//  in_data    in   WIDTH  word under test
//  ref_load   in   1      load ref_data/ref_mask this cycle
//  ref_data   in   WIDTH  new reference value
//  ref_mask   in   WIDTH  new compare mask; 1 = bit compared, 0 = don't-care
//  out_valid  out  1      result valid
//  out_ready  in   1      downstream accepts result
//  out_match  out  1      1 = all compared bits equal
//  out_diff   out  WIDTH  per-bit mismatch: (in_data ^ ref) & mask
//  cnt_clr    in   1      synchronous clear of match_cnt
//  match_cnt  out  CNT_W  count of matched results handed off
// BEHAVIOUR
//  Reset (rst_n low, async)
//   - s1_v, s2_v, out_valid, out_match, out_diff, match_cnt = 0.
//   - ref = 0; mask = all ones.
//   - Reset mid-stream discards in-flight words, with no partial output.
//  Pipeline: two register stages, latency 2 cycles from input handshake to out_valid with no stall.
//   - S1: eq_vec = XNOR(in_data, ref) | ~mask, registered with s1_v.
//   - S2: match = &eq_vec; diff = ~eq_vec, registered with s2_v; drives out_*.
//  Handshake
//   - Transfer only when valid && ready.
//   - s2_rdy = !s2_v || out_ready; s1_rdy = !s1_v || s2_rdy; in_ready = s1_rdy (combinational).
//   - Full throughput: 1 word/cycle while out_ready is high.
//   - Stall: out_valid/out_match/out_diff hold stable while out_valid && !out_ready. No drop, no duplicate.
//   - in_ready must not depend on in_valid.
//  Reference load
//   - ref_load updates ref and mask on the clock edge.
//   - A word accepted in the same cycle as ref_load compares against the OLD reference.
//   - Words already in S1/S2 are unaffected; their S1 result is already registered.
//  Counter
//   - Increments on out_valid && out_ready && out_match.
//   - Holds at 2**CNT_W-1 (saturates, never wraps).
//   - cnt_clr has priority: a clear coinciding with a matching handshake yields 0.
//  Edge cases
//   - mask = 0: every word matches and out_diff = 0.
//   - WIDTH = 2 must work. No X on outputs after reset.
// STRUCTURE
//  - Sub-module xnor_vec_nor_g #(WIDTH): WIDTH-bit XNOR built only from gate-level nor primitives,
//    6 NORs per bit.
//  - The OR-with-~mask and the AND reduction are RTL in the top level.
//  - Shared package xnor_pkg:
//    - localparam LAT = 2;
//    - function sat_inc(cnt, max);
//    - typedef for the S1/S2 stage struct (valid, eq_vec).
// TESTING
//  - Reset: rst_n=0 then 1 -> out_valid=0, match_cnt=0, in_ready=1.
//  - W=8, ref=8'hA5, mask=8'hFF, stream A5,A4,A5 with out_ready=1 -> out_match 1,0,1 at +2 cycles;
//    out_diff=00,01,00; match_cnt=2.
//  - mask=8'hF0, ref=8'hA0, in=8'hAF -> out_match=1, out_diff=00.
//    in=8'hB0 -> out_match=0, out_diff=8'h10.
//  - out_ready=0 for 5 cycles while in_valid=1 -> in_ready drops after 2 accepts;
//    outputs stay stable; on release all words arrive in order, none lost.
//  - ref_load (ref=8'h3C) in the same cycle a word 8'h3C is accepted, old ref=0
//    -> that word mismatches and the next 8'h3C matches.
//  - CNT_W=2, 5 matches -> match_cnt saturates at 3.
//    cnt_clr coinciding with a match -> 0. Async reset mid-stall -> all valids 0 immediately.

Source files
------------

// File: rtl/xnor_pkg.sv
// rtl/xnor_pkg.sv - shared constants, stage struct and saturating increment for xnor_match_pipe
package xnor_pkg;

    // Cycles from input handshake to out_valid when nothing stalls.
    localparam int LAT   = 2;

    // Upper bound on WIDTH. The stage struct carries MAX_W compare bits; bits
    // above WIDTH are padded with ones so they never affect the AND reduction.
    localparam int MAX_W = 64;

    typedef struct packed {
        logic             valid;
        logic [MAX_W-1:0] eq_vec;
    } stage_t;

    // Increment that sticks at max instead of wrapping.
    function automatic logic [31:0] sat_inc(input logic [31:0] cnt, input logic [31:0] max);
        return (cnt >= max) ? max : cnt + 32'd1;
    endfunction

endpackage

// File: rtl/xnor_vec_nor_g.sv
// rtl/xnor_vec_nor_g.sv - WIDTH-bit XNOR built from nor primitives only
//
// Ports
//   i_a  in  WIDTH  first operand
//   i_b  in  WIDTH  second operand
//   o_y  out WIDTH  bitwise XNOR of i_a and i_b
module xnor_vec_nor_g #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_y
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        wire w_n1;
        wire w_n2;
        wire w_n3;
        wire w_n4;
        wire w_n5;
        // n2 = ~a & b, n3 = a & ~b, n4 = ~(n2 | n3) = XNOR.
        nor u_n1 (w_n1, i_a[i], i_b[i]);
        nor u_n2 (w_n2, i_a[i], w_n1);
        nor u_n3 (w_n3, i_b[i], w_n1);
        nor u_n4 (w_n4, w_n2, w_n3);
        // Two inverting NORs form a buffer so the cell drives a full-strength output.
        nor u_n5 (w_n5, w_n4, w_n4);
        nor u_n6 (o_y[i], w_n5, w_n5);
    end

endmodule

// File: rtl/xnor_match_pipe.sv
// rtl/xnor_match_pipe.sv - two-stage masked word comparator with valid/ready and saturating match counter
//
// Ports
//   clk        in   1      rising-edge clock
//   rst_n      in   1      asynchronous active-low reset
//   in_valid   in   1      input word valid
//   in_ready   out  1      input word accepted this cycle when in_valid
//   in_data    in   WIDTH  word under test
//   ref_load   in   1      load ref_data/ref_mask at this edge
//   ref_data   in   WIDTH  new reference value
//   ref_mask   in   WIDTH  new compare mask (1 = compared)
//   out_valid  out  1      result valid
//   out_ready  in   1      downstream accepts result
//   out_match  out  1      all compared bits equal
//   out_diff   out  WIDTH  per-bit mismatch under mask
//   cnt_clr    in   1      synchronous clear of match_cnt
//   match_cnt  out  CNT_W  saturating count of matching results handed off
module xnor_match_pipe
    import xnor_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             ref_load,
    input  logic [WIDTH-1:0] ref_data,
    input  logic [WIDTH-1:0] ref_mask,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_match,
    output logic [WIDTH-1:0] out_diff,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] match_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [WIDTH-1:0] r_ref;
    logic [WIDTH-1:0] r_mask;
    stage_t           r_s1;
    logic             r_s2_v;
    logic             r_match;
    logic [WIDTH-1:0] r_diff;
    logic [CNT_W-1:0] r_cnt;

    logic [WIDTH-1:0] w_xnor;
    logic [MAX_W-1:0] w_eq_full;
    logic             w_s2_rdy;
    logic             w_s1_rdy;
    logic             w_out_hs;

    xnor_vec_nor_g #(.WIDTH(WIDTH)) u_xnor (
        .i_a (in_data),
        .i_b (r_ref),
        .o_y (w_xnor)
    );

    // Masked-off bits count as equal; padding bits are ones so the full-width
    // reduction in S2 only sees the real WIDTH bits.
    assign w_eq_full = {{(MAX_W-WIDTH){1'b1}}, w_xnor | ~r_mask};

    assign w_s2_rdy = !r_s2_v || out_ready;
    assign w_s1_rdy = !r_s1.valid || w_s2_rdy;
    assign in_ready = w_s1_rdy;
    assign w_out_hs = r_s2_v && out_ready;

    // The current word is compared against r_ref before this edge updates it,
    // so a word accepted alongside ref_load sees the old reference.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ref  <= '0;
            r_mask <= '1;
        end else if (ref_load) begin
            r_ref  <= ref_data;
            r_mask <= ref_mask;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1 <= '0;
        end else if (w_s1_rdy) begin
            r_s1.valid <= in_valid;
            if (in_valid) begin
                r_s1.eq_vec <= w_eq_full;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_v  <= 1'b0;
            r_match <= 1'b0;
            r_diff  <= '0;
        end else if (w_s2_rdy) begin
            r_s2_v <= r_s1.valid;
            if (r_s1.valid) begin
                r_match <= &r_s1.eq_vec;
                r_diff  <= ~r_s1.eq_vec[WIDTH-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (cnt_clr) begin
            r_cnt <= '0;
        end else if (w_out_hs && r_match) begin
            r_cnt <= CNT_W'(sat_inc(32'(r_cnt), 32'(CNT_MAX)));
        end
    end

    assign out_valid = r_s2_v;
    assign out_match = r_match;
    assign out_diff  = r_diff;
    assign match_cnt = r_cnt;

endmodule
